apb_uart_master: RTL and testbench

- APB initiator that drives the UART's APB register slave from a simple command/response interface (CPU-side or test sequencer).
- Converts one command into one APB transfer: IDLE, then SETUP, then ACCESS.
- Waits for P_READY, returns read data, and aborts with an error flag if the slave stalls too long.
- Sits between the system command source and the UART register block; drives on rising pclk, which the slave samples on falling pclk.

---
 rtl/apb_uart_pkg.sv | 24 ++
 rtl/apb_wait_timer.sv | 44 ++++
 rtl/apb_uart_master.sv | 158 +++++++++++++++
 tb/tb_apb_uart_master.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_pkg.sv
// -----------------------------------------------------------------------------
// apb_uart_pkg
//   Shared definitions for the APB initiator that drives the UART register
//   slave: FSM state encoding, default bus widths and the UART register map.
// -----------------------------------------------------------------------------
package apb_uart_pkg;

  // Default geometry: 8-bit registers, four register addresses.
  localparam int DEFAULT_BITWIDTH   = 8;
  localparam int DEFAULT_ADDR_WIDTH = 2;
  localparam int DEFAULT_TIMEOUT    = 16;

  // UART register map (subset the command source commonly targets).
  localparam logic [DEFAULT_ADDR_WIDTH-1:0] ADDR_BAUD   = 2'd0;
  localparam logic [DEFAULT_ADDR_WIDTH-1:0] ADDR_TXDATA = 2'd2;

  // APB transfer phases. Encoding 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

endpackage : apb_uart_pkg

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
//   Counts ACCESS cycles spent waiting for P_READY. The count saturates at
//   TIMEOUT-1, which is the point where the master aborts the transfer, so it
//   never wraps regardless of how long enable stays high.
//
// Ports
//   pclk      in   APB clock, rising-edge state updates
//   presetn   in   asynchronous active-low reset
//   clear     in   load zero on the next edge (has priority over enable)
//   enable    in   advance the count by one on the next edge
//   terminal  out  count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module apb_wait_timer #(
  parameter int TIMEOUT = 16  // legal range 2..255
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  // ceil(log2(TIMEOUT)) bits are exactly enough to hold 0..TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  assign terminal = (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule : apb_wait_timer

// File: rtl/apb_uart_master.sv
// -----------------------------------------------------------------------------
// apb_uart_master
//   Converts one command from a valid/ready command port into one APB
//   transfer (IDLE -> SETUP -> ACCESS) toward the UART register slave, and
//   returns a single-cycle response carrying read data or a timeout error.
//   Bus outputs change on rising pclk; the slave samples them on falling pclk.
//
// Ports
//   pclk, presetn               APB clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (accepted only in IDLE)
//   cmd_write/addr/wdata        command fields, sampled at the handshake edge
//   resp_valid                  one-cycle pulse when a transfer ends
//   resp_rdata                  last read data, held between responses
//   resp_err                    1 = slave stalled TIMEOUT cycles, transfer aborted
//   psel/penable/pwrite         APB control
//   P_ADDR/PW_DATA              APB address / write data (held in IDLE)
//   Pr_data/P_READY             APB read data / ready from the slave
// -----------------------------------------------------------------------------
module apb_uart_master
  import apb_uart_pkg::*;
#(
  parameter int BITWIDTH   = DEFAULT_BITWIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT     // legal range 2..255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [BITWIDTH-1:0]   cmd_wdata,
  // response side
  output logic                  resp_valid,
  output logic [BITWIDTH-1:0]   resp_rdata,
  output logic                  resp_err,
  // APB side
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] P_ADDR,
  output logic [BITWIDTH-1:0]   PW_DATA,
  input  logic [BITWIDTH-1:0]   Pr_data,
  input  logic                  P_READY
);

  apb_state_t state, state_next;

  logic handshake;     // command accepted this cycle
  logic finish_ok;     // slave completed the ACCESS phase
  logic finish_abort;  // wait budget exhausted with P_READY still low
  logic timer_clear;
  logic timer_enable;
  logic timer_done;

  // ---------------------------------------------------------------------------
  // Wait timer: cleared while in SETUP so ACCESS always starts from zero,
  // advanced on every ACCESS edge that sees P_READY low.
  // ---------------------------------------------------------------------------
  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .pclk     (pclk),
    .presetn  (presetn),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .terminal (timer_done)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cmd_valid)                state_next = SETUP;
      SETUP:                                 state_next = ACCESS;
      ACCESS:  if (P_READY || timer_done)    state_next = IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // cmd_ready is gated by presetn so it drops the instant reset asserts,
    // without waiting for the state register to be observed.
    cmd_ready    = presetn && (state == IDLE);
    handshake    = cmd_valid && cmd_ready;
    finish_ok    = (state == ACCESS) && P_READY;
    finish_abort = (state == ACCESS) && !P_READY && timer_done;
    timer_clear  = (state == SETUP);
    timer_enable = (state == ACCESS) && !P_READY;
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered bus/response outputs.
  // pwrite/P_ADDR/PW_DATA keep their last values in IDLE; only psel/penable
  // return to zero. resp_rdata only changes on a successful read.
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      P_ADDR     <= '0;
      PW_DATA    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;

      if (handshake) begin
        pwrite  <= cmd_write;
        P_ADDR  <= cmd_addr;
        PW_DATA <= cmd_wdata;
        psel    <= 1'b1;
        penable <= 1'b0;
      end

      if (state == SETUP) begin
        penable <= 1'b1;
      end

      if (finish_ok) begin
        if (!pwrite) begin
          resp_rdata <= Pr_data;
        end
        resp_valid <= 1'b1;
        resp_err   <= 1'b0;
        psel       <= 1'b0;
        penable    <= 1'b0;
      end else if (finish_abort) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b1;
        psel       <= 1'b0;
        penable    <= 1'b0;
      end
    end
  end

endmodule : apb_uart_master

// File: tb/tb_apb_uart_master.sv
// -----------------------------------------------------------------------------
// tb_apb_uart_master
//   Scoreboard bench: the command driver computes each expected response
//   (error flag, read data, completion cycle) from the transfer rules and
//   queues it; a monitor pops and compares whenever resp_valid is seen. A slave
//   model answers ACCESS phases with a per-command number of wait cycles and
//   drives random noise on P_READY/Pr_data outside ACCESS.
// -----------------------------------------------------------------------------
module tb_apb_uart_master;
  import apb_uart_pkg::*;

  localparam int BW = 8;
  localparam int AW = 2;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [BW-1:0] cmd_wdata;
  logic          resp_valid;
  logic [BW-1:0] resp_rdata;
  logic          resp_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] P_ADDR;
  logic [BW-1:0] PW_DATA;
  logic [BW-1:0] Pr_data = '0;
  logic          P_READY = 1'b0;

  apb_uart_master #(
    .BITWIDTH   (BW),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .P_ADDR     (P_ADDR),
    .PW_DATA    (PW_DATA),
    .Pr_data    (Pr_data),
    .P_READY    (P_READY)
  );

  always #5 pclk = ~pclk;

  // Rising-edge counter; the value seen at a falling edge names the rising
  // edge that just occurred.
  int unsigned cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    int            waits;   // ACCESS edges with P_READY low before it rises
    logic [BW-1:0] rdata;   // data the slave returns on a read
  } bus_item_t;

  typedef struct {
    logic          err;
    logic [BW-1:0] rdata;
    int unsigned   edge_n;
  } resp_item_t;

  bus_item_t  slave_q[$];
  resp_item_t exp_q[$];
  logic [BW-1:0] model_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Slave model (acts on falling edges, as the UART register block does)
  // ---------------------------------------------------------------------------
  bus_item_t cur;
  int        acc_k = 0;

  always @(negedge pclk) begin : slave_model
    bus_item_t it;
    if (psel && !penable) begin
      if (slave_q.size() == 0) begin
        fail("setup_without_command");
      end else begin
        it = slave_q.pop_front();
        check("setup_addr",   P_ADDR,  it.addr);
        check("setup_pwrite", pwrite,  it.write);
        check("setup_wdata",  PW_DATA, it.wdata);
        cur   <= it;
        acc_k <= 0;
      end
      // Noise during SETUP must be ignored by the master.
      P_READY <= 1'($urandom_range(0, 1));
      Pr_data <= BW'($urandom);
    end else if (psel && penable) begin
      check("access_hold", {pwrite, P_ADDR, PW_DATA}, {cur.write, cur.addr, cur.wdata});
      P_READY <= (acc_k == cur.waits);
      Pr_data <= cur.write ? BW'($urandom) : cur.rdata;
      acc_k   <= acc_k + 1;
    end else begin
      P_READY <= 1'($urandom_range(0, 1));
      Pr_data <= BW'($urandom);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus protocol monitor
  // ---------------------------------------------------------------------------
  logic prev_setup = 1'b0;
  always @(negedge pclk) begin : protocol_monitor
    if (psel) check("setup_single_cycle", prev_setup && !penable, 1'b0);
    if (penable) check("penable_implies_psel", psel, 1'b1);
    prev_setup <= psel && !penable;
  end

  // ---------------------------------------------------------------------------
  // Response monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge pclk) begin : resp_monitor
    resp_item_t e;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        fail("resp_unexpected");
      end else begin
        e = exp_q.pop_front();
        check("resp_err",     resp_err,   e.err);
        check("resp_rdata",   resp_rdata, e.rdata);
        check("resp_edge",    cyc,        e.edge_n);
        check("idle_at_resp", {psel, penable, cmd_ready}, 3'b001);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: must be entered at a falling edge; returns at the falling edge
  // after the handshake (master in SETUP).
  // ---------------------------------------------------------------------------
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d,
                      input int waits, input logic [BW-1:0] rd, input bit hold,
                      output int unsigned hs_edge);
    int         guard;
    int         eff;
    bus_item_t  b;
    resp_item_t r;
    guard   = 0;
    hs_edge = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready) begin
      @(negedge pclk);
      guard++;
      if (guard > 100) begin
        fail("cmd_ready_timeout");
        cmd_valid = 1'b0;
        return;
      end
    end
    hs_edge = cyc + 1;
    b = '{w, a, d, waits, rd};
    slave_q.push_back(b);
    // Reference rules: a stall of TIMEOUT ACCESS edges aborts with rdata kept;
    // otherwise the response lands after waits+1 ACCESS edges, and only a
    // successful read updates the returned data.
    r.err = (waits >= TO);
    eff   = r.err ? TO - 1 : waits;
    if (!r.err && !w) model_rdata = rd;
    r.rdata  = model_rdata;
    r.edge_n = hs_edge + 2 + eff;
    exp_q.push_back(r);
    @(negedge pclk);
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = BW'($urandom);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    cmd_valid = 1'b0;
    while ((exp_q.size() != 0 || !cmd_ready) && g < 100) begin
      @(negedge pclk);
      g++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
    @(negedge pclk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int unsigned hs1, hs2;
    logic        w;
    int          waits;
    int          gap;
    bit          hold;

    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;

    #12;
    check("rst_psel",       psel,       1'b0);
    check("rst_penable",    penable,    1'b0);
    check("rst_pwrite",     pwrite,     1'b0);
    check("rst_paddr",      P_ADDR,     '0);
    check("rst_pwdata",     PW_DATA,    '0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, '0);
    check("rst_resp_err",   resp_err,   1'b0);
    check("rst_cmd_ready",  cmd_ready,  1'b0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check("idle_cmd_ready", cmd_ready, 1'b1);

    // Zero-wait write to the baud register.
    send(1'b1, ADDR_BAUD, 8'h1A, 0, 8'h00, 1'b0, hs1);
    check("w0_setup_ctl",   {psel, penable}, 2'b10);
    check("w0_setup_addr",  P_ADDR,  ADDR_BAUD);
    check("w0_setup_wdata", PW_DATA, 8'h1A);
    @(negedge pclk);
    check("w0_access_ctl",  {psel, penable}, 2'b11);
    drain();

    // Read of TXDATA address with two wait states.
    send(1'b0, ADDR_TXDATA, 8'h00, 2, 8'h5C, 1'b0, hs1);
    drain();

    // Stuck slave: abort after TIMEOUT ACCESS cycles, read data retained.
    send(1'b0, 2'd1, 8'h00, 9, 8'hEE, 1'b0, hs1);
    drain();

    // Back-to-back with cmd_valid held high.
    send(1'b1, ADDR_TXDATA, 8'h33, 0, 8'h00, 1'b1, hs1);
    send(1'b0, ADDR_BAUD,   8'h00, 0, 8'hA7, 1'b0, hs2);
    check("b2b_spacing", hs2 - hs1, 32'd3);
    drain();

    // Reset during an ACCESS wait: bus drops without a clock edge.
    send(1'b0, 2'd3, 8'h00, 3, 8'h11, 1'b0, hs1);
    @(negedge pclk);
    @(negedge pclk);
    #1;
    presetn = 1'b0;
    #1;
    check("mid_rst_bus",       {psel, penable}, 2'b00);
    check("mid_rst_cmd_ready", cmd_ready, 1'b0);
    check("mid_rst_rdata",     resp_rdata, '0);
    exp_q.delete();
    slave_q.delete();
    model_rdata = '0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    send(1'b1, 2'd1, 8'hC3, 1, 8'h00, 1'b0, hs1);
    drain();

    // Randomized traffic with random gaps and occasional back-to-back.
    for (int i = 0; i < 40; i++) begin
      w     = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 5);
      hold  = (i != 39) && ($urandom_range(0, 2) == 0);
      send(w, AW'($urandom), BW'($urandom), waits, BW'($urandom), hold, hs1);
      if (!hold) begin
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge pclk);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_apb_uart_master
